mem_port_arbiter: RTL

Shares the single synchronous block-RAM port of the CR16 multicycle datapath between the CPU (instruction fetch, LOAD, STOR) and one auxiliary requester (I/O or display DMA). CPU has fixed priority, bounded by a starvation counter that guarantees the auxiliary port service within MAX_WAIT cycles. A lock mode supports an atomic CPU read-modify-write. The block sits between the control FSM / PC address mux and the BRAM.

---
 rtl/cr16_mem_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cr16_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cr16_mem_pkg
// Purpose  : Shared widths, arbiter state and port-select encodings for the
//            CR16 block-RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cr16_mem_pkg;

    localparam int c_ADDR_W = 10;
    localparam int c_DATA_W = 16;

    typedef enum logic [0:0] {
        ST_OPEN = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_AUX  = 2'd2
    } port_sel_e;

endpackage : cr16_mem_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous BRAM port between the CPU (fixed priority,
//            with an atomic lock mode) and an auxiliary requester.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cr16_mem_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic              i_cpu_lock,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_aux_req,
    input  logic              i_aux_we,
    input  logic [ADDR_W-1:0] i_aux_addr,
    input  logic [DATA_W-1:0] i_aux_wdata,
    output logic              o_aux_gnt,
    output logic              o_aux_rvalid,
    output logic [DATA_W-1:0] o_aux_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int                c_CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(MAX_WAIT);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    port_sel_e          w_sel;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [c_CNT_W-1:0] w_wait_nxt;
    logic               w_eff_lock;
    logic               w_starved;
    logic               r_cpu_rvalid;
    logic               r_aux_rvalid;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_aux_rdata;

    // Dropping cpu_lock releases the port in the same cycle it is seen.
    assign w_eff_lock = (r_state == ST_LOCK) && i_cpu_lock;
    assign w_starved  = (r_wait_cnt == c_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_OPEN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_sel       = SEL_NONE;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;

        if (!reset) begin
            w_sel = SEL_NONE;
        end else if (w_eff_lock) begin
            if (i_cpu_req) w_sel = SEL_CPU;
        end else if (i_aux_req && w_starved) begin
            w_sel = SEL_AUX;
        end else if (i_cpu_req) begin
            w_sel = SEL_CPU;
        end else if (i_aux_req) begin
            w_sel = SEL_AUX;
        end

        case (w_sel)
            SEL_CPU: begin
                o_mem_en    = 1'b1;
                o_mem_we    = i_cpu_we;
                o_mem_addr  = i_cpu_addr;
                o_mem_wdata = i_cpu_wdata;
            end
            SEL_AUX: begin
                o_mem_en    = 1'b1;
                o_mem_we    = i_aux_we;
                o_mem_addr  = i_aux_addr;
                o_mem_wdata = i_aux_wdata;
            end
            default: ;
        endcase

        if (w_eff_lock) begin
            if (w_sel == SEL_CPU && i_cpu_we) w_state_nxt = ST_OPEN;
        end else begin
            w_state_nxt = ST_OPEN;
            if (w_sel == SEL_CPU && !i_cpu_we && i_cpu_lock) w_state_nxt = ST_LOCK;
        end

        if (!i_aux_req || w_sel == SEL_AUX) begin
            w_wait_nxt = '0;
        end else if (!w_starved) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    assign o_cpu_gnt = (w_sel == SEL_CPU);
    assign o_aux_gnt = (w_sel == SEL_AUX);

    // BRAM data is only valid during the rvalid cycle; capture it for the hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rvalid <= 1'b0;
            r_aux_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_aux_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= o_cpu_gnt && !i_cpu_we;
            r_aux_rvalid <= o_aux_gnt && !i_aux_we;
            if (r_cpu_rvalid) r_cpu_rdata <= i_mem_rdata;
            if (r_aux_rvalid) r_aux_rdata <= i_mem_rdata;
        end
    end

    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_aux_rvalid = r_aux_rvalid;
    assign o_cpu_rdata  = r_cpu_rvalid ? i_mem_rdata : r_cpu_rdata;
    assign o_aux_rdata  = r_aux_rvalid ? i_mem_rdata : r_aux_rdata;

endmodule : mem_port_arbiter
`default_nettype wire
